// File: rtl/ifm_buf_sched.sv
// ifm_buf_sched: IFM row-buffer fill scheduler. Loads rows in order into a ring of IFM_BUF_CNT buffers.
// Define IFM_SCHED_ERR_EN to build the sticky protocol checker behind o_err; otherwise o_err is tied low.
module ifm_buf_sched #(
    parameter int W_SIZE      = 12,
    parameter int IFM_BUF_CNT = 4,
    parameter int W_IFM_BUF   = 2,
    parameter int W_ADDR      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_start,
    input  logic [W_SIZE-1:0]      q_height,
    input  logic [W_ADDR-1:0]      q_base_addr,
    input  logic [W_ADDR-1:0]      q_row_stride,
    output logic                   o_ld_req,
    output logic [W_ADDR-1:0]      o_ld_addr,
    output logic [W_IFM_BUF-1:0]   o_ld_buf_id,
    output logic [W_SIZE-1:0]      o_ld_row,
    input  logic                   i_ld_ack,
    input  logic                   i_ld_done,
    input  logic                   i_row_done,
    output logic [IFM_BUF_CNT-1:0] o_ifm_buf_done,
    output logic                   o_busy,
    output logic                   o_sched_done,
    output logic                   o_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [W_SIZE-1:0]    ONE_S   = W_SIZE'(1);
    localparam logic [W_SIZE-1:0]    OCC_MAX = W_SIZE'(IFM_BUF_CNT - 1);
    localparam logic [W_IFM_BUF-1:0] ONE_B   = W_IFM_BUF'(1);

    state_t                 state_q, state_nx;
    logic [W_SIZE-1:0]      ld_row_q, cons_row_q, freed_q, height_q;
    logic [W_ADDR-1:0]      addr_q, stride_q;
    logic [IFM_BUF_CNT-1:0] flags_q, flags_nx;
    logic                   sched_done_q;

    logic                   start_go, busy, ld_fire, rel, rel_last, rel_free, done_nx;
    logic [W_SIZE-1:0]      ld_row_nx, freed_nx, occ_q, occ_nx;
    logic                   can_load_q, can_load_nx;
    logic [W_IFM_BUF-1:0]   ld_idx, rel_idx;

    assign start_go  = (state_q == ST_IDLE) && q_start;
    assign busy      = (state_q != ST_IDLE);
    assign ld_fire   = (state_q == ST_WAIT) && i_ld_done;
    assign rel       = busy && i_row_done;
    assign rel_last  = rel && (cons_row_q == height_q - ONE_S);
    assign rel_free  = rel && (cons_row_q != '0);
    assign ld_row_nx = ld_fire ? ld_row_q + ONE_S : ld_row_q;
    assign freed_nx  = rel_free ? freed_q + ONE_S : freed_q;
    assign occ_q     = ld_row_q - freed_q;
    assign occ_nx    = ld_row_nx - freed_nx;
    assign ld_idx    = ld_row_q[W_IFM_BUF-1:0];
    assign rel_idx   = cons_row_q[W_IFM_BUF-1:0] - ONE_B;
    assign done_nx   = (start_go && (q_height == '0)) || rel_last;

    // ld_row counts rows already loaded, i.e. it is the next row to fetch; one slot always stays free
    assign can_load_q  = (ld_row_q < height_q) && (occ_q < OCC_MAX);
    assign can_load_nx = (ld_row_nx < height_q) && (occ_nx < OCC_MAX);

    // Clear is applied before set so a set wins on a (never expected) collision
    always_comb begin
        flags_nx = flags_q;
        if (rel_free)
            flags_nx[rel_idx] = 1'b0;
        if (ld_fire)
            flags_nx[ld_idx] = 1'b1;
        if (rel_last || start_go)
            flags_nx = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: if (q_start && (q_height != '0)) state_nx = ST_REQ;
            ST_REQ:  if (i_ld_ack) state_nx = ST_WAIT;
            ST_WAIT: if (i_ld_done) state_nx = can_load_nx ? ST_REQ : ST_HOLD;
            ST_HOLD: if (can_load_q) state_nx = ST_REQ;
            default: state_nx = ST_IDLE;
        endcase
        if (rel_last)
            state_nx = ST_IDLE;
    end

    always_comb begin
        o_ld_req    = 1'b0;
        o_ld_addr   = '0;
        o_ld_buf_id = '0;
        o_ld_row    = '0;
        if (state_q == ST_REQ) begin
            o_ld_req    = 1'b1;
            o_ld_addr   = addr_q;
            o_ld_buf_id = ld_idx;
            o_ld_row    = ld_row_q;
        end
    end

    assign o_busy         = busy;
    assign o_ifm_buf_done = flags_q;
    assign o_sched_done   = sched_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_row_q     <= '0;
            cons_row_q   <= '0;
            freed_q      <= '0;
            flags_q      <= '0;
            sched_done_q <= 1'b0;
        end else begin
            ld_row_q     <= start_go ? '0 : ld_row_nx;
            freed_q      <= start_go ? '0 : freed_nx;
            flags_q      <= flags_nx;
            sched_done_q <= done_nx;
            if (start_go)
                cons_row_q <= '0;
            else if (rel && !rel_last)
                cons_row_q <= cons_row_q + ONE_S;
        end
    end

    // Frame geometry and address are data: only observed through the gated request outputs
    always_ff @(posedge clk) begin
        if (start_go) begin
            height_q <= q_height;
            stride_q <= q_row_stride;
            addr_q   <= q_base_addr;
        end else if (ld_fire) begin
            addr_q   <= addr_q + stride_q;
        end
    end

`ifdef IFM_SCHED_ERR_EN
    logic                 err_q, err_set, chk_flag;
    logic [W_IFM_BUF-1:0] chk_idx;

    // Row r needs row min(r+1, height-1) resident before it can legally be reported done
    assign chk_idx  = (cons_row_q + ONE_S < height_q) ? cons_row_q[W_IFM_BUF-1:0] + ONE_B
                                                      : height_q[W_IFM_BUF-1:0] - ONE_B;
    assign chk_flag = flags_q[chk_idx];
    assign err_set  = (i_ld_done && (state_q != ST_WAIT)) ||
                      (i_ld_ack && (state_q != ST_REQ)) ||
                      (i_row_done && (!busy || !chk_flag));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifm_buf_sched.sv
// Directed self-checking bench for ifm_buf_sched (default parameters, 4 buffers).
module tb_ifm_buf_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        q_start = 1'b0;
    logic [11:0] q_height = '0;
    logic [31:0] q_base_addr = '0;
    logic [31:0] q_row_stride = '0;
    logic        o_ld_req;
    logic [31:0] o_ld_addr;
    logic [1:0]  o_ld_buf_id;
    logic [11:0] o_ld_row;
    logic        i_ld_ack = 1'b0;
    logic        i_ld_done = 1'b0;
    logic        i_row_done = 1'b0;
    logic [3:0]  o_ifm_buf_done;
    logic        o_busy;
    logic        o_sched_done;
    logic        o_err;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_flags;
`ifdef IFM_SCHED_ERR_EN
    localparam logic EXP_ERR_STRAY = 1'b1;
`else
    localparam logic EXP_ERR_STRAY = 1'b0;
`endif

    ifm_buf_sched dut (
        .clk(clk), .rst(rst), .q_start(q_start), .q_height(q_height),
        .q_base_addr(q_base_addr), .q_row_stride(q_row_stride),
        .o_ld_req(o_ld_req), .o_ld_addr(o_ld_addr), .o_ld_buf_id(o_ld_buf_id),
        .o_ld_row(o_ld_row), .i_ld_ack(i_ld_ack), .i_ld_done(i_ld_done),
        .i_row_done(i_row_done), .o_ifm_buf_done(o_ifm_buf_done), .o_busy(o_busy),
        .o_sched_done(o_sched_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [11:0] h, input logic [31:0] base, input logic [31:0] stride);
        q_start = 1'b1; q_height = h; q_base_addr = base; q_row_stride = stride;
        tick();
        q_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({o_ld_req, o_ld_addr, o_ld_buf_id, o_ld_row, o_ifm_buf_done, o_busy, o_sched_done, o_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%b addr=%h buf=%h row=%h flags=%b busy=%b done=%b err=%b want all 0",
                     o_ld_req, o_ld_addr, o_ld_buf_id, o_ld_row, o_ifm_buf_done, o_busy, o_sched_done, o_err);
        end
        rst = 1'b0;
        tick();
    endtask

    // Height 6: rows 0..2 load back to back, then the ring is full and the scheduler holds
    task automatic test_fill();
        start_frame(12'd6, 32'h1000, 32'h100);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!(o_ld_req === 1'b1 && o_ld_addr === 32'h1000 + 32'(i) * 32'h100 &&
                  o_ld_buf_id === 2'(i) && o_ld_row === 12'(i))) begin
                failures++;
                $display("FAIL fill_req row%0d: got req=%b addr=%h buf=%0d row=%0d want 1/%h/%0d/%0d",
                         i, o_ld_req, o_ld_addr, o_ld_buf_id, o_ld_row, 32'h1000 + 32'(i) * 32'h100, i, i);
            end
            i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
            checks++;
            if (o_ld_req !== 1'b0) begin
                failures++; $display("FAIL fill_req_drop row%0d: got %b want 0", i, o_ld_req);
            end
            i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
        end
        tick();
        checks++;
        if (!(o_ifm_buf_done === 4'b0111 && o_ld_req === 1'b0 && o_busy === 1'b1)) begin
            failures++;
            $display("FAIL fill_hold: got flags=%b req=%b busy=%b want 0111/0/1", o_ifm_buf_done, o_ld_req, o_busy);
        end
    endtask

    // Continues the height-6 frame: release rows 0..5 and check recycling and the final pulse
    task automatic test_release();
        exp_flags = 4'b0111;
        i_row_done = 1'b1; tick(); i_row_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b0111 && o_ld_req === 1'b0)) begin
            failures++; $display("FAIL rel_row0: got flags=%b req=%b want 0111/0", o_ifm_buf_done, o_ld_req);
        end
        for (int r = 1; r <= 3; r++) begin
            i_row_done = 1'b1; tick(); i_row_done = 1'b0;
            exp_flags[(r - 1) % 4] = 1'b0;
            checks++;
            if (!(o_ifm_buf_done === exp_flags && o_ld_req === 1'b0)) begin
                failures++;
                $display("FAIL rel_clear row%0d: got flags=%b req=%b want %b/0", r, o_ifm_buf_done, o_ld_req, exp_flags);
            end
            tick();
            checks++;
            if (!(o_ld_req === 1'b1 && o_ld_row === 12'(r + 2) && o_ld_buf_id === 2'((r + 2) % 4) &&
                  o_ld_addr === 32'h1000 + 32'(r + 2) * 32'h100)) begin
                failures++;
                $display("FAIL rel_reload row%0d: got req=%b row=%0d buf=%0d addr=%h want 1/%0d/%0d/%h",
                         r, o_ld_req, o_ld_row, o_ld_buf_id, o_ld_addr, r + 2, (r + 2) % 4,
                         32'h1000 + 32'(r + 2) * 32'h100);
            end
            i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
            i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
            exp_flags[(r + 2) % 4] = 1'b1;
            checks++;
            if (!(o_ifm_buf_done === exp_flags && o_ld_req === 1'b0)) begin
                failures++;
                $display("FAIL rel_loaded row%0d: got flags=%b req=%b want %b/0", r + 2, o_ifm_buf_done, o_ld_req, exp_flags);
            end
        end
        i_row_done = 1'b1; tick(); i_row_done = 1'b0;
        tick();
        checks++;
        if (!(o_ifm_buf_done === 4'b0011 && o_ld_req === 1'b0 && o_busy === 1'b1 && o_sched_done === 1'b0)) begin
            failures++;
            $display("FAIL rel_row4: got flags=%b req=%b busy=%b done=%b want 0011/0/1/0",
                     o_ifm_buf_done, o_ld_req, o_busy, o_sched_done);
        end
        i_row_done = 1'b1; tick(); i_row_done = 1'b0;
        checks++;
        if (!(o_sched_done === 1'b1 && o_busy === 1'b0 && o_ifm_buf_done === 4'b0000)) begin
            failures++;
            $display("FAIL rel_last: got done=%b busy=%b flags=%b want 1/0/0000", o_sched_done, o_busy, o_ifm_buf_done);
        end
        tick();
        checks++;
        if (o_sched_done !== 1'b0) begin
            failures++; $display("FAIL rel_done_pulse: got %b want 0", o_sched_done);
        end
    endtask

    // Height 2 with a 5-cycle ack delay: request fields must hold steady
    task automatic test_ack_delay();
        start_frame(12'd2, 32'h2000, 32'h40);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (!(o_ld_req === 1'b1 && o_ld_addr === 32'h2000 && o_ld_buf_id === 2'd0 && o_ld_row === 12'd0)) begin
                failures++;
                $display("FAIL ack_stable cyc%0d: got req=%b addr=%h buf=%0d row=%0d want 1/2000/0/0",
                         c, o_ld_req, o_ld_addr, o_ld_buf_id, o_ld_row);
            end
            tick();
        end
        i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
        i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b0001 && o_ld_req === 1'b1 && o_ld_addr === 32'h2040 && o_ld_buf_id === 2'd1)) begin
            failures++;
            $display("FAIL ack_row1: got flags=%b req=%b addr=%h buf=%0d want 0001/1/2040/1",
                     o_ifm_buf_done, o_ld_req, o_ld_addr, o_ld_buf_id);
        end
        i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
        i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b0011 && o_ld_req === 1'b0)) begin
            failures++; $display("FAIL ack_all_loaded: got flags=%b req=%b want 0011/0", o_ifm_buf_done, o_ld_req);
        end
        i_row_done = 1'b1; tick(); tick();
        i_row_done = 1'b0;
        checks++;
        if (!(o_sched_done === 1'b1 && o_ifm_buf_done === 4'b0000 && o_busy === 1'b0)) begin
            failures++;
            $display("FAIL ack_frame_end: got done=%b flags=%b busy=%b want 1/0000/0", o_sched_done, o_ifm_buf_done, o_busy);
        end
        tick();
    endtask

    task automatic test_height1();
        start_frame(12'd1, 32'h3000, 32'h80);
        checks++;
        if (!(o_ld_req === 1'b1 && o_ld_addr === 32'h3000 && o_ld_row === 12'd0)) begin
            failures++; $display("FAIL h1_req: got req=%b addr=%h row=%0d want 1/3000/0", o_ld_req, o_ld_addr, o_ld_row);
        end
        i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
        i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b0001 && o_ld_req === 1'b0)) begin
            failures++; $display("FAIL h1_loaded: got flags=%b req=%b want 0001/0", o_ifm_buf_done, o_ld_req);
        end
        i_row_done = 1'b1; tick(); i_row_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b0000 && o_sched_done === 1'b1 && o_busy === 1'b0)) begin
            failures++;
            $display("FAIL h1_done: got flags=%b done=%b busy=%b want 0000/1/0", o_ifm_buf_done, o_sched_done, o_busy);
        end
        tick();
    endtask

    task automatic test_height0();
        start_frame(12'd0, 32'h4000, 32'h80);
        checks++;
        if (!(o_sched_done === 1'b1 && o_ld_req === 1'b0 && o_busy === 1'b0)) begin
            failures++;
            $display("FAIL h0_done: got done=%b req=%b busy=%b want 1/0/0", o_sched_done, o_ld_req, o_busy);
        end
        tick();
        checks++;
        if (!(o_sched_done === 1'b0 && o_ld_req === 1'b0)) begin
            failures++; $display("FAIL h0_after: got done=%b req=%b want 0/0", o_sched_done, o_ld_req);
        end
    endtask

    // Load-done for row 3 coinciding with row-done for row 2, then abort with reset mid-load
    task automatic test_simultaneous_and_abort();
        start_frame(12'd6, 32'h1000, 32'h100);
        for (int i = 0; i < 3; i++) begin
            i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
            i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
        end
        i_row_done = 1'b1; tick(); tick(); i_row_done = 1'b0;
        tick();
        checks++;
        if (!(o_ld_req === 1'b1 && o_ld_row === 12'd3 && o_ifm_buf_done === 4'b0110)) begin
            failures++;
            $display("FAIL sim_pre: got req=%b row=%0d flags=%b want 1/3/0110", o_ld_req, o_ld_row, o_ifm_buf_done);
        end
        i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
        i_ld_done = 1'b1; i_row_done = 1'b1; tick();
        i_ld_done = 1'b0; i_row_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b1100 && o_ld_req === 1'b1 && o_ld_row === 12'd4 &&
              o_ld_buf_id === 2'd0 && o_ld_addr === 32'h1400)) begin
            failures++;
            $display("FAIL sim_setclr: got flags=%b req=%b row=%0d buf=%0d addr=%h want 1100/1/4/0/1400",
                     o_ifm_buf_done, o_ld_req, o_ld_row, o_ld_buf_id, o_ld_addr);
        end
        i_ld_ack = 1'b1; tick(); i_ld_ack = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_ld_req, o_ld_addr, o_ld_buf_id, o_ld_row, o_ifm_buf_done, o_busy, o_sched_done, o_err} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got req=%b flags=%b busy=%b done=%b err=%b want all 0",
                     o_ld_req, o_ifm_buf_done, o_busy, o_sched_done, o_err);
        end
        tick();
        rst = 1'b0;
        tick();
        i_ld_done = 1'b1; tick(); i_ld_done = 1'b0;
        checks++;
        if (!(o_ifm_buf_done === 4'b0000 && o_busy === 1'b0 && o_ld_req === 1'b0)) begin
            failures++;
            $display("FAIL stray_done: got flags=%b busy=%b req=%b want 0000/0/0", o_ifm_buf_done, o_busy, o_ld_req);
        end
        checks++;
        if (o_err !== EXP_ERR_STRAY) begin
            failures++; $display("FAIL stray_err: got %b want %b", o_err, EXP_ERR_STRAY);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_ack_delay();
        test_height1();
        test_height0();
        test_simultaneous_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
